div_ctrl: RTL

- Iterative divider controller/datapath for the execute stage. Serves DIV/DIVU.
- Accepts operands from EX, sequences one restoring-division step per clock, and returns {remainder, quotient} for HI/LO.
- EX holds the pipeline stalled until ready_o is asserted.

---
 rtl/div_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, MSB first,
// with sign fix-up on completion and a start/ready handshake towards EX.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_e;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 sdiv_q, sdiv_d;
    logic                 sgn1_q, sgn1_d;
    logic                 sgn2_q, sgn2_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     shifted_s;
    logic [WIDTH-1:0]     diff_s;
    logic                 ge_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    // Restoring step: the shifted partial remainder is W+1 bits; its top bit is rem_q MSB.
    always_comb begin
        shifted_s = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        diff_s    = shifted_s - dvsr_q;
        ge_s      = rem_q[WIDTH-1] | (shifted_s >= dvsr_q);
        quo_fix_s = (sdiv_q && (sgn1_q ^ sgn2_q)) ? neg(quo_q) : quo_q;
        rem_fix_s = (sdiv_q && sgn1_q) ? neg(rem_q) : rem_q;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        sdiv_d   = sdiv_q;
        sgn1_d   = sgn1_q;
        sgn2_d   = sgn2_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            ST_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = ST_BYZERO;
                    end else begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = (signed_div_i && opdata1_i[WIDTH-1]) ? neg(opdata1_i) : opdata1_i;
                        dvsr_d  = (signed_div_i && opdata2_i[WIDTH-1]) ? neg(opdata2_i) : opdata2_i;
                        sdiv_d  = signed_div_i;
                        sgn1_d  = opdata1_i[WIDTH-1];
                        sgn2_d  = opdata2_i[WIDTH-1];
                    end
                end else begin
                    state_d = ST_FREE;
                end
            end
            ST_BYZERO: begin
                state_d  = ST_END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d  = ST_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != CW'(WIDTH)) begin
                    if (ge_s) begin
                        rem_d = diff_s;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted_s;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d  = ST_END;
                    result_d = {rem_fix_s, quo_fix_s};
                    ready_d  = 1'b1;
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_d  = ST_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    state_d = ST_END;
                end
            end
            default: begin
                state_d  = ST_FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            sdiv_q   <= 1'b0;
            sgn1_q   <= 1'b0;
            sgn2_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            sdiv_q   <= sdiv_d;
            sgn1_q   <= sgn1_d;
            sgn2_q   <= sgn2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign busy_o   = (state_q == ST_BYZERO) || (state_q == ST_ON);
    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
